// File: rtl/xgen_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : xgen_seq                                                        |
// | Purpose  : Time-multiplexed, runtime-programmable spatial-transform        |
// |            generator. For a request (link, sin q, cos q) it produces 15     |
// |            entries E_k = Ks*sinq + Kc*cosq + K0, one entry per cycle, using |
// |            two shared multipliers and a per-link constant table that is    |
// |            loaded over a config port.                                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        clock                                                         |
// |   reset      asynchronous, active-high reset (also clears the table)       |
// |   cfg_we     constant write strobe (honoured only while idle)              |
// |   cfg_link   link being written                                            |
// |   cfg_entry  entry 0..14                                                   |
// |   cfg_term   0=Ks, 1=Kc, 2=K0                                              |
// |   cfg_data   constant value                                                |
// |   cfg_err    1-cycle pulse: the write was dropped                          |
// |   in_valid   request valid                                                 |
// |   in_ready   block idle, can accept                                        |
// |   link_in    link index of the request                                     |
// |   sinq_in    sin(q), signed fixed point                                    |
// |   cosq_in    cos(q), signed fixed point                                    |
// |   out_valid  result bank valid                                             |
// |   out_ready  downstream accepts                                            |
// |   link_out   link of the result                                            |
// |   out_err    requested link was >= NUM_LINKS (entries forced to 0)        |
// |   xform_out  entry k at [k*WIDTH +: WIDTH]                                 |
// +----------------------------------------------------------------------------+
// | Build option                                                               |
// |   XGEN_SEQ_SATURATE_EN  defined : three-term sum clamped to WIDTH range     |
// |                         undefined: sum wraps (low WIDTH bits), bit-exact   |
// |                                    with the fixed xgen blocks              |
// +----------------------------------------------------------------------------+
module xgen_seq #(
    parameter int WIDTH        = 32,
    parameter int DECIMAL_BITS = 16,
    parameter int NUM_LINKS    = 7,
    parameter int LINK_W       = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [LINK_W-1:0]     cfg_link,
    input  logic [3:0]            cfg_entry,
    input  logic [1:0]            cfg_term,
    input  logic [WIDTH-1:0]      cfg_data,
    output logic                  cfg_err,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LINK_W-1:0]     link_in,
    input  logic [WIDTH-1:0]      sinq_in,
    input  logic [WIDTH-1:0]      cosq_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LINK_W-1:0]     link_out,
    output logic                  out_err,
    output logic [15*WIDTH-1:0]   xform_out
);

    localparam int              c_NUM_ENTRIES = 15;
    localparam logic [3:0]      c_LAST_ENTRY  = 4'd14;
    localparam logic [LINK_W:0] c_NUM_LINKS_X = (LINK_W+1)'(NUM_LINKS);

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_COMPUTE = 2'd1;
    localparam logic [1:0] c_S_DONE    = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;

    logic [3:0]        r_cnt;
    logic [LINK_W-1:0] r_link;
    logic              r_err;
    logic [WIDTH-1:0]  r_sin;
    logic [WIDTH-1:0]  r_cos;
    logic              r_cfg_err;
    logic [WIDTH-1:0]  r_bank [c_NUM_ENTRIES];
    logic [WIDTH-1:0]  r_tbl  [NUM_LINKS][c_NUM_ENTRIES][3];

    logic              w_accept;
    logic              w_link_in_ok;
    logic              w_cfg_ok;
    logic [LINK_W-1:0] w_rd_link;
    logic [WIDTH-1:0]  w_ks;
    logic [WIDTH-1:0]  w_kc;
    logic [WIDTH-1:0]  w_k0;
    logic signed [2*WIDTH-1:0] w_prod_s;
    logic signed [2*WIDTH-1:0] w_prod_c;
    logic [WIDTH-1:0]  w_term_s;
    logic [WIDTH-1:0]  w_term_c;
    logic signed [WIDTH+1:0]   w_sum;
    logic [WIDTH-1:0]  w_result;
    logic [WIDTH-1:0]  w_entry;
    logic              w_unused_prod;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = c_S_COMPUTE;
                end
            end
            c_S_COMPUTE: begin
                if (r_cnt == c_LAST_ENTRY) begin
                    w_next_state = c_S_DONE;
                end
            end
            c_S_DONE: begin
                // in_ready stays low here even when the handshake completes,
                // so a new request can only be taken from the next cycle on.
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = c_S_IDLE;
                end
            end
            default: begin
                w_next_state = c_S_IDLE;
            end
        endcase
    end

    assign w_accept     = (r_state == c_S_IDLE) && in_valid;
    assign w_link_in_ok = ({1'b0, link_in} < c_NUM_LINKS_X);
    assign w_cfg_ok     = (r_state == c_S_IDLE) &&
                          (cfg_entry <= c_LAST_ENTRY) &&
                          (cfg_term != 2'd3) &&
                          ({1'b0, cfg_link} < c_NUM_LINKS_X);

    // ------------------------------------------------------------------
    // Datapath: one entry per COMPUTE cycle, two shared multipliers.
    // ------------------------------------------------------------------
    // An out-of-range link still walks all 15 entries (timing unchanged);
    // the table is read at link 0 only to keep the index legal, and the
    // result is forced to zero below.
    assign w_rd_link = r_err ? '0 : r_link;
    assign w_ks      = r_tbl[w_rd_link][r_cnt][0];
    assign w_kc      = r_tbl[w_rd_link][r_cnt][1];
    assign w_k0      = r_tbl[w_rd_link][r_cnt][2];

    assign w_prod_s = $signed(w_ks) * $signed(r_sin);
    assign w_prod_c = $signed(w_kc) * $signed(r_cos);

    // Arithmetic shift right by DECIMAL_BITS followed by truncation to
    // WIDTH is exactly this bit slice of the full product (floor rounding).
    assign w_term_s = w_prod_s[DECIMAL_BITS +: WIDTH];
    assign w_term_c = w_prod_c[DECIMAL_BITS +: WIDTH];

    assign w_unused_prod = ^{w_prod_s[2*WIDTH-1:DECIMAL_BITS+WIDTH], w_prod_s[DECIMAL_BITS-1:0],
                             w_prod_c[2*WIDTH-1:DECIMAL_BITS+WIDTH], w_prod_c[DECIMAL_BITS-1:0]};

    // Two guard bits hold the sum of three WIDTH-bit signed terms exactly.
    assign w_sum = {{2{w_term_s[WIDTH-1]}}, w_term_s}
                 + {{2{w_term_c[WIDTH-1]}}, w_term_c}
                 + {{2{w_k0[WIDTH-1]}},     w_k0};

`ifdef XGEN_SEQ_SATURATE_EN
    localparam logic signed [WIDTH+1:0] c_SUM_MAX = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH+1:0] c_SUM_MIN = {3'b111, {(WIDTH-1){1'b0}}};

    always_comb begin
        w_result = w_sum[WIDTH-1:0];
        if (w_sum > c_SUM_MAX) begin
            w_result = c_SUM_MAX[WIDTH-1:0];
        end else if (w_sum < c_SUM_MIN) begin
            w_result = c_SUM_MIN[WIDTH-1:0];
        end
    end
`else
    logic w_unused_sum;

    assign w_result     = w_sum[WIDTH-1:0];
    assign w_unused_sum = ^w_sum[WIDTH+1:WIDTH];
`endif

    assign w_entry = r_err ? '0 : w_result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_link    <= '0;
            r_err     <= 1'b0;
            r_sin     <= '0;
            r_cos     <= '0;
            r_cfg_err <= 1'b0;
            for (int k = 0; k < c_NUM_ENTRIES; k++) begin
                r_bank[k] <= '0;
            end
        end else begin
            r_cfg_err <= cfg_we && !w_cfg_ok;
            if (w_accept) begin
                r_cnt  <= '0;
                r_link <= link_in;
                r_err  <= !w_link_in_ok;
                r_sin  <= sinq_in;
                r_cos  <= cosq_in;
            end
            if (r_state == c_S_COMPUTE) begin
                r_bank[r_cnt] <= w_entry;
                if (r_cnt != c_LAST_ENTRY) begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Constant table. A write in the same idle cycle as an accepted
    // request lands on that edge, so COMPUTE (from the next cycle) sees it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int l = 0; l < NUM_LINKS; l++) begin
                for (int e = 0; e < c_NUM_ENTRIES; e++) begin
                    for (int t = 0; t < 3; t++) begin
                        r_tbl[l][e][t] <= '0;
                    end
                end
            end
        end else if (cfg_we && w_cfg_ok) begin
            r_tbl[cfg_link][cfg_entry][cfg_term] <= cfg_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cfg_err  = r_cfg_err;
    assign link_out = r_link;
    assign out_err  = r_err;

    generate
        for (genvar k = 0; k < c_NUM_ENTRIES; k++) begin : g_pack
            assign xform_out[k*WIDTH +: WIDTH] = r_bank[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_xgen_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_xgen_seq                                                     |
// | Purpose  : Self-checking bench for xgen_seq. A reference model of the      |
// |            constant table and the entry equation predicts each result;     |
// |            expectations are queued at accept and compared by a monitor.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_xgen_seq;

    localparam int W  = 32;
    localparam int NL = 7;
    localparam int LW = 3;
    localparam int NE = 15;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cfg_we = 1'b0;
    logic [LW-1:0]   cfg_link = '0;
    logic [3:0]      cfg_entry = '0;
    logic [1:0]      cfg_term = '0;
    logic [W-1:0]    cfg_data = '0;
    logic            cfg_err;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [LW-1:0]   link_in = '0;
    logic [W-1:0]    sinq_in = '0;
    logic [W-1:0]    cosq_in = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [LW-1:0]   link_out;
    logic            out_err;
    logic [NE*W-1:0] xform_out;

    xgen_seq #(
        .WIDTH(W), .DECIMAL_BITS(16), .NUM_LINKS(NL), .LINK_W(LW)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_link(cfg_link), .cfg_entry(cfg_entry),
        .cfg_term(cfg_term), .cfg_data(cfg_data), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .link_in(link_in),
        .sinq_in(sinq_in), .cosq_in(cosq_in),
        .out_valid(out_valid), .out_ready(out_ready), .link_out(link_out),
        .out_err(out_err), .xform_out(xform_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int mtbl [NL][NE][3];
    bit hold_rdy = 1'b0;

    typedef struct {
        logic [LW-1:0]   link;
        logic            err;
        logic [NE*W-1:0] x;
        int              edge_no;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string nm, input logic [NE*W-1:0] act, input logic [NE*W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // One entry from the rules: floor(K*x / 2^16) kept to 32 bits, exact sum,
    // then clamp or wrap to 32 bits.
    function automatic logic [W-1:0] ref_entry(int ks, int kc, int k0, int s, int c);
        longint ps, pc, sum;
        ps  = (longint'(ks) * longint'(s)) >>> 16;
        pc  = (longint'(kc) * longint'(c)) >>> 16;
        sum = longint'(int'(ps)) + longint'(int'(pc)) + longint'(k0);
`ifdef XGEN_SEQ_SATURATE_EN
        if (sum > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (sum < -64'sd2147483648) return 32'h8000_0000;
`endif
        return sum[W-1:0];
    endfunction

    function automatic exp_t mk_exp(int l, int s, int c);
        exp_t e;
        e.link    = l[LW-1:0];
        e.err     = (l >= NL);
        e.x       = '0;
        e.edge_no = 0;
        if (l < NL) begin
            for (int k = 0; k < NE; k++) begin
                e.x[k*W +: W] = ref_entry(mtbl[l][k][0], mtbl[l][k][1], mtbl[l][k][2], s, c);
            end
        end
        return e;
    endfunction

    // Downstream backpressure, changed just after the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares every cycle a result is presented, pops on handshake.
    initial begin
        exp_t e;
        bit   prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 1'b0;
            end else if (out_valid) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: out_valid=1 with nothing outstanding");
                end else begin
                    e = sbq[0];
                    if (!prev_valid) begin
                        chk("latency", NE*W'(cyc - e.edge_no), NE*W'(15));
                    end
                    chk("link_err", {out_err, link_out}, {e.err, e.link});
                    chk("xform", xform_out, e.x);
                    chk("in_ready_busy", in_ready, 1'b0);
                    if (out_ready) begin
                        void'(sbq.pop_front());
                    end
                end
                prev_valid = 1'b1;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    task automatic do_cfg(input int l, input int en, input int tm, input logic [W-1:0] d);
        bit ok;
        @(negedge clk);
        ok = in_ready && (en <= 14) && (tm != 3) && (l < NL);
        cfg_we    = 1'b1;
        cfg_link  = l[LW-1:0];
        cfg_entry = en[3:0];
        cfg_term  = tm[1:0];
        cfg_data  = d;
        if (ok) mtbl[l][en][tm] = int'(d);
        @(negedge clk);
        cfg_we = 1'b0;
        chk("cfg_err", cfg_err, !ok);
    endtask

    // Request, optionally with a table write in the same cycle.
    task automatic do_req(input int l, input logic [W-1:0] s, input logic [W-1:0] c,
                          input bit wcfg, input int wl, input int we, input int wt,
                          input logic [W-1:0] wd);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("req_timeout", in_ready, 1'b1);
            return;
        end
        if (wcfg) begin
            cfg_we    = 1'b1;
            cfg_link  = wl[LW-1:0];
            cfg_entry = we[3:0];
            cfg_term  = wt[1:0];
            cfg_data  = wd;
            mtbl[wl][we][wt] = int'(wd);
        end
        in_valid = 1'b1;
        link_in  = l[LW-1:0];
        sinq_in  = s;
        cosq_in  = c;
        e = mk_exp(l, int'(s), int'(c));
        e.edge_no = cyc + 1;
        sbq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        if (wcfg) chk("cfg_err_with_req", cfg_err, 1'b0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sbq.size() != 0 || !in_ready) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_timeout", NE*W'(sbq.size()), '0);
    endtask

    function automatic logic [W-1:0] rnd_q();
        if ($urandom_range(0, 1) == 1) return $urandom;
        return W'(int'($urandom_range(0, 131072)) - 65536);
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int l = 0; l < NL; l++)
            for (int e = 0; e < NE; e++)
                for (int t = 0; t < 3; t++) mtbl[l][e][t] = 0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_errs_link", {cfg_err, out_err, link_out}, '0);
        chk("rst_xform", xform_out, '0);
        reset = 1'b0;

        // T1/T2 table and requests
        do_cfg(0, 0, 1, -32'sd65536);
        do_cfg(0, 2, 0, 32'd65536);
        do_cfg(0, 6, 2, 32'd65536);
        do_cfg(0, 8, 0, 32'd5308);
        do_cfg(0, 10, 1, 32'd5308);
        do_cfg(0, 11, 1, 32'd5308);
        do_cfg(0, 13, 0, -32'sd5308);
        do_req(0, 32'd0, 32'd65536, 1'b0, 0, 0, 0, '0);
        drain();
        do_req(0, 32'd65536, 32'd0, 1'b0, 0, 0, 0, '0);
        drain();

        // T3 backpressure: held result stable, in_valid ignored while busy
        hold_rdy = 1'b1;
        do_req(0, 32'd46341, -32'sd46341, 1'b0, 0, 0, 0, '0);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            in_valid = !in_ready;
            link_in  = 3'd2;
            sinq_in  = $urandom;
            cosq_in  = $urandom;
        end
        in_valid = 1'b0;
        hold_rdy = 1'b0;
        drain();

        // T4 bad link; config during COMPUTE dropped; bad writes in idle
        do_req(7, 32'd65536, 32'd65536, 1'b0, 0, 0, 0, '0);
        do_cfg(0, 0, 1, 32'd123);
        drain();
        do_cfg(0, 15, 0, 32'd1);
        do_cfg(0, 3, 3, 32'd1);
        do_cfg(7, 3, 0, 32'd1);
        do_req(0, 32'd0, 32'd65536, 1'b0, 0, 0, 0, '0);
        drain();

        // T5 overflow of the three-term sum
        do_cfg(1, 0, 0, 32'h7FFF_0000);
        do_cfg(1, 0, 2, 32'h7FFF_0000);
        do_req(1, 32'd65536, 32'd0, 1'b0, 0, 0, 0, '0);
        drain();

        // Same-cycle write and request: the new constant must be used
        do_req(2, 32'd65536, 32'd65536, 1'b1, 2, 3, 2, 32'h0001_2345);
        drain();

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            for (int w = 0; w < 4; w++) begin
                if ($urandom_range(0, 5) == 0)
                    do_cfg($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 3), $urandom);
                else
                    do_cfg($urandom_range(0, NL-1), $urandom_range(0, 14), $urandom_range(0, 2),
                           ($urandom_range(0, 1) == 1) ? $urandom : W'(int'($urandom_range(0, 131072)) - 65536));
            end
            do_req($urandom_range(0, 7), rnd_q(), rnd_q(), $urandom_range(0, 3) == 0,
                   $urandom_range(0, NL-1), $urandom_range(0, 14), $urandom_range(0, 2), $urandom);
        end
        drain();

        // T6 reset in the middle of COMPUTE (after the edge that leaves cnt=7)
        do_req(0, 32'd65536, 32'd65536, 1'b0, 0, 0, 0, '0);
        repeat (7) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_xform", xform_out, '0);
        sbq.delete();
        for (int l = 0; l < NL; l++)
            for (int e = 0; e < NE; e++)
                for (int t = 0; t < 3; t++) mtbl[l][e][t] = 0;
        @(negedge clk);
        reset = 1'b0;
        do_req(0, 32'd65536, 32'd65536, 1'b0, 0, 0, 0, '0);
        drain();
        do_req(1, 32'd65536, 32'd0, 1'b0, 0, 0, 0, '0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
